// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - RV32 5-stage hazard/forwarding unit with multi-cycle load freeze.
// Optional HAZARD_PERF_EN adds saturating lwstall/flush/memwait event counters.
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 0,
    parameter int LAT_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic [1:0]        resultsrc_e,
    input  logic [1:0]        resultsrc_m,
    input  logic              pcsrc_e,
    output logic [1:0]        forward1,
    output logic [1:0]        forward2,
    output logic              stallf,
    output logic              stalld,
    output logic              stalle,
    output logic              stallm,
    output logic              stallw,
    output logic              flushd,
    output logic              flushe,
    output logic [CNT_W-1:0]  perf_lwstall,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_memwait
);

    typedef enum logic {
        ST_RUN,
        ST_MWAIT
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               held_q, held_d;
    logic               freeze;
    logic               lwstall;
    logic               load_m;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic [REG_AW-1:0] rdw,
        input logic              rwm,
        input logic              rww,
        input logic [1:0]        srcm
    );
        if (rs == '0)                                 return 2'b00;
        else if (srcm == 2'b11 && rs == rdm)          return 2'b11;
        else if (rwm && srcm != 2'b01 && rs == rdm)   return 2'b10;
        else if (rww && rs == rdw)                    return 2'b01;
        else                                          return 2'b00;
    endfunction

    assign load_m  = regwrite_m && (resultsrc_m == 2'b01);
    assign lwstall = regwrite_e && (resultsrc_e == 2'b01) && (rd_e != '0)
                   && ((use_rs1_d && rd_e == rs1_d) || (use_rs2_d && rd_e == rs2_d));

    // held_q marks the release cycle of a single-cycle freeze: the same load is still in M.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        held_d    = 1'b0;
        freeze    = 1'b0;
        if (MEM_LAT != 0) begin
            case (state_q)
                ST_RUN: begin
                    if (load_m && !held_q) begin
                        freeze = 1'b1;
                        if (MEM_LAT == 1) begin
                            held_d = 1'b1;
                        end else begin
                            state_d   = ST_MWAIT;
                            lat_cnt_d = LAT_W'(MEM_LAT - 1);
                        end
                    end
                end
                ST_MWAIT: begin
                    if (lat_cnt_q != '0) begin
                        freeze    = 1'b1;
                        lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            lat_cnt_q <= '0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            held_q    <= held_d;
        end
    end

    // A branch arriving while frozen stays in E, so pcsrc_e simply flushes on release.
    always_comb begin
        forward1 = 2'b00;
        forward2 = 2'b00;
        stallf   = 1'b0;
        stalld   = 1'b0;
        stalle   = 1'b0;
        stallm   = 1'b0;
        stallw   = 1'b0;
        flushd   = 1'b1;
        flushe   = 1'b1;
        if (!reset) begin
            forward1 = fwd_sel(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w, resultsrc_m);
            forward2 = fwd_sel(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w, resultsrc_m);
            if (freeze) begin
                stallf = 1'b1;
                stalld = 1'b1;
                stalle = 1'b1;
                stallm = 1'b1;
                stallw = 1'b1;
                flushd = 1'b0;
                flushe = 1'b0;
            end else begin
                stallf = lwstall && !pcsrc_e;
                stalld = lwstall && !pcsrc_e;
                flushd = pcsrc_e;
                flushe = pcsrc_e || lwstall;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] perf_lw_q, perf_fl_q, perf_mw_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lw_q <= '0;
            perf_fl_q <= '0;
            perf_mw_q <= '0;
        end else begin
            if (lwstall && !freeze && perf_lw_q != CNT_MAX)
                perf_lw_q <= perf_lw_q + CNT_W'(1);
            if (pcsrc_e && !freeze && perf_fl_q != CNT_MAX)
                perf_fl_q <= perf_fl_q + CNT_W'(1);
            if (freeze && perf_mw_q != CNT_MAX)
                perf_mw_q <= perf_mw_q + CNT_W'(1);
        end
    end

    assign perf_lwstall = perf_lw_q;
    assign perf_flush   = perf_fl_q;
    assign perf_memwait = perf_mw_q;
`else
    assign perf_lwstall = '0;
    assign perf_flush   = '0;
    assign perf_memwait = '0;
`endif

endmodule
